// File: rtl/knn_pkg.sv
// Shared types and sizing helpers for the KNN classifier: FSM encoding and
// distance width derivation used by the controller, register bank and bench.
package knn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_CALC   = 3'd2,
        ST_INSERT = 3'd3,
        ST_VOTE   = 3'd4,
        ST_DONE   = 3'd5
    } knn_state_t;

    localparam int NBR_CNT_W = 4;

    // Squared distance of two (DATA_W+1)-bit differences never exceeds this width.
    function automatic int dist_width(input int data_w);
        return 2 * data_w + 1;
    endfunction

endpackage

// File: rtl/knn_if.sv
// Training-point memory bus: controller issues a read, memory returns the
// point and its label one cycle later.
interface knn_if #(
    parameter int DATA_W  = 16,
    parameter int N_W     = 10,
    parameter int LABEL_W = 2
) ();
    logic                      mem_en;
    logic [N_W-1:0]            mem_addr;
    logic signed [DATA_W-1:0]  mem_x;
    logic signed [DATA_W-1:0]  mem_y;
    logic [LABEL_W-1:0]        mem_label;

    modport master (
        output mem_en, mem_addr,
        input  mem_x, mem_y, mem_label
    );

    modport slave (
        input  mem_en, mem_addr,
        output mem_x, mem_y, mem_label
    );
endinterface

// File: rtl/knn_sort_list.sv
// K-entry nearest-neighbour list kept sorted ascending by distance; a new
// entry is placed after all entries with distance <= its own (stable ties).
module knn_sort_list #(
    parameter int K       = 4,
    parameter int DIST_W  = 33,
    parameter int LABEL_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 ins,
    input  logic [DIST_W-1:0]    ins_dist,
    input  logic [LABEL_W-1:0]   ins_label,
    output logic [DIST_W-1:0]    head_dist,
    output logic [K*LABEL_W-1:0] label_flat,
    output logic [K-1:0]         valid
);
    logic [DIST_W-1:0]  dist_reg   [K];
    logic [LABEL_W-1:0] label_reg  [K];
    logic [K-1:0]       valid_reg;
    logic [K-1:0]       le;
    logic [K:0]         le_ext;
    logic [DIST_W-1:0]  prev_dist  [K];
    logic [LABEL_W-1:0] prev_label [K];
    logic [K-1:0]       prev_valid;

    assign le_ext[0] = 1'b1;
    assign valid     = valid_reg;
    assign head_dist = dist_reg[0];

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_entry
            // Valid entries form a sorted prefix, so le is a thermometer code
            // and the insert slot is the first zero.
            assign le[gi]         = valid_reg[gi] && (dist_reg[gi] <= ins_dist);
            assign le_ext[gi + 1] = le[gi];
            assign label_flat[gi*LABEL_W +: LABEL_W] = label_reg[gi];

            if (gi == 0) begin : g_first
                assign prev_dist[gi]  = '0;
                assign prev_label[gi] = '0;
                assign prev_valid[gi] = 1'b0;
            end else begin : g_rest
                assign prev_dist[gi]  = dist_reg[gi-1];
                assign prev_label[gi] = label_reg[gi-1];
                assign prev_valid[gi] = valid_reg[gi-1];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                    dist_reg[gi]  <= '0;
                    label_reg[gi] <= '0;
                end else if (clr) begin
                    valid_reg[gi] <= 1'b0;
                end else if (ins && !le[gi]) begin
                    if (le_ext[gi]) begin
                        valid_reg[gi] <= 1'b1;
                        dist_reg[gi]  <= ins_dist;
                        label_reg[gi] <= ins_label;
                    end else begin
                        valid_reg[gi] <= prev_valid[gi];
                        dist_reg[gi]  <= prev_dist[gi];
                        label_reg[gi] <= prev_label[gi];
                    end
                end
            end
        end
    endgenerate
endmodule

// File: rtl/knn_ctrl.sv
// KNN sequencing controller: scans training points, keeps the K nearest in a
// sorted list and reports the majority label of those neighbours.
module knn_ctrl
    import knn_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int N_W     = 10,
    parameter int K       = 4,
    parameter int LABEL_W = 2,
    localparam int DIST_W = dist_width(DATA_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] test_x,
    input  logic signed [DATA_W-1:0] test_y,
    input  logic [N_W:0]             n_points,
    knn_if.master                    mem,
    output logic                     busy,
    output logic                     done,
    output logic [LABEL_W-1:0]       result_label,
    output logic [DIST_W-1:0]        min_dist,
    output logic [NBR_CNT_W-1:0]     nbr_count
);
    localparam int NCLS = 1 << LABEL_W;

    knn_state_t           state_reg, state_next;
    logic [DATA_W-1:0]    tx_reg, ty_reg;
    logic [N_W:0]         n_reg, idx_reg, idx_inc;
    logic [DIST_W-1:0]    dist_reg;
    logic [LABEL_W-1:0]   label_reg;
    logic                 list_clr, list_ins;
    logic [DIST_W-1:0]    list_head;
    logic [K*LABEL_W-1:0] list_label;
    logic [K-1:0]         list_valid;

    // Differences need one extra bit; sign-extending to DIST_W keeps the
    // square exact since it always fits in DIST_W-1 bits.
    logic [DATA_W:0]      dx, dy;
    logic [DIST_W-1:0]    dx_ext, dy_ext, dist_calc;

    assign dx        = {mem.mem_x[DATA_W-1], mem.mem_x} - {tx_reg[DATA_W-1], tx_reg};
    assign dy        = {mem.mem_y[DATA_W-1], mem.mem_y} - {ty_reg[DATA_W-1], ty_reg};
    assign dx_ext    = {{DATA_W{dx[DATA_W]}}, dx};
    assign dy_ext    = {{DATA_W{dy[DATA_W]}}, dy};
    assign dist_calc = dx_ext * dx_ext + dy_ext * dy_ext;
    assign idx_inc   = idx_reg + (N_W+1)'(1);

    knn_sort_list #(.K(K), .DIST_W(DIST_W), .LABEL_W(LABEL_W)) u_list (
        .clk        (clk),
        .rst        (rst),
        .clr        (list_clr),
        .ins        (list_ins),
        .ins_dist   (dist_reg),
        .ins_label  (label_reg),
        .head_dist  (list_head),
        .label_flat (list_label),
        .valid      (list_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        list_clr   = 1'b0;
        list_ins   = 1'b0;
        case (state_reg)
            ST_IDLE: if (start) begin
                list_clr   = 1'b1;
                state_next = (n_points == '0) ? ST_VOTE : ST_READ;
            end
            ST_READ:   state_next = ST_CALC;
            ST_CALC:   state_next = ST_INSERT;
            ST_INSERT: begin
                list_ins   = 1'b1;
                state_next = (idx_inc == n_reg) ? ST_VOTE : ST_READ;
            end
            ST_VOTE:   state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign mem.mem_en   = (state_reg == ST_READ);
    assign mem.mem_addr = (state_reg == ST_READ) ? idx_reg[N_W-1:0] : '0;
    assign busy         = (state_reg != ST_IDLE);
    assign done         = (state_reg == ST_DONE);

    logic [NBR_CNT_W-1:0] cls_cnt [NCLS];
    logic [NBR_CNT_W-1:0] best_cnt, nbr_next;
    logic [LABEL_W-1:0]   win_label;

    always_comb begin
        nbr_next = '0;
        for (int c = 0; c < NCLS; c++) cls_cnt[c] = '0;
        for (int j = 0; j < K; j++) begin
            if (list_valid[j]) begin
                nbr_next = nbr_next + NBR_CNT_W'(1);
                for (int c = 0; c < NCLS; c++)
                    if (list_label[j*LABEL_W +: LABEL_W] == LABEL_W'(c))
                        cls_cnt[c] = cls_cnt[c] + NBR_CNT_W'(1);
            end
        end
    end

    // Strict '>' scanning upward leaves ties with the lowest class index.
    always_comb begin
        best_cnt  = '0;
        win_label = '0;
        for (int c = 0; c < NCLS; c++) begin
            if (cls_cnt[c] > best_cnt) begin
                best_cnt  = cls_cnt[c];
                win_label = LABEL_W'(c);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_reg       <= '0;
            ty_reg       <= '0;
            n_reg        <= '0;
            idx_reg      <= '0;
            dist_reg     <= '0;
            label_reg    <= '0;
            result_label <= '0;
            min_dist     <= '1;
            nbr_count    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: if (start) begin
                    tx_reg  <= test_x;
                    ty_reg  <= test_y;
                    n_reg   <= n_points;
                    idx_reg <= '0;
                end
                ST_CALC: begin
                    dist_reg  <= dist_calc;
                    label_reg <= mem.mem_label;
                end
                ST_INSERT: idx_reg <= idx_inc;
                ST_VOTE: begin
                    result_label <= win_label;
                    min_dist     <= list_valid[0] ? list_head : '1;
                    nbr_count    <= nbr_next;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_knn_ctrl.sv
// Directed bench for knn_ctrl: hand-computed KNN scenarios, timing and
// control corner cases against a registered-read training memory model.
module tb_knn_ctrl;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic signed [15:0] test_x = '0;
    logic signed [15:0] test_y = '0;
    logic [10:0]        n_points = '0;
    logic               busy, done;
    logic [1:0]         result_label;
    logic [32:0]        min_dist;
    logic [3:0]         nbr_count;

    int errors = 0;
    int checks = 0;

    logic signed [15:0] px [1024];
    logic signed [15:0] py [1024];
    logic [1:0]         pl [1024];

    localparam logic [32:0] ALL_ONES = {33{1'b1}};

    knn_if #(.DATA_W(16), .N_W(10), .LABEL_W(2)) bus ();

    knn_ctrl #(.DATA_W(16), .N_W(10), .K(4), .LABEL_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .test_x       (test_x),
        .test_y       (test_y),
        .n_points     (n_points),
        .mem          (bus),
        .busy         (busy),
        .done         (done),
        .result_label (result_label),
        .min_dist     (min_dist),
        .nbr_count    (nbr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            bus.mem_x     <= px[bus.mem_addr];
            bus.mem_y     <= py[bus.mem_addr];
            bus.mem_label <= pl[bus.mem_addr];
        end
    end

    task automatic set_pt(input int idx, input int x, input int y, input int l);
        px[idx] = 16'(x);
        py[idx] = 16'(y);
        pl[idx] = 2'(l);
    endtask

    task automatic load_basic();
        set_pt(0, 1, 0, 1);
        set_pt(1, 0, 2, 2);
        set_pt(2, 3, 3, 1);
        set_pt(3, -1, -1, 1);
        set_pt(4, 5, 0, 3);
    endtask

    task automatic load_ties();
        set_pt(0, 2, 0, 2);
        set_pt(1, 0, -2, 1);
    endtask

    // Starts a run, returns cycles from the start edge to the done cycle,
    // mem_en cycles seen, busy just after start and busy/done one edge after done.
    task automatic run(input int n, input int x, input int y, input int poke,
                       output int lat, output int en_cnt, output logic busy0,
                       output logic busy_after, output logic done_after);
        @(negedge clk);
        test_x = 16'(x); test_y = 16'(y); n_points = 11'(n); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy0 = busy;
        lat = 0; en_cnt = 0;
        while (done !== 1'b1 && lat < 300) begin
            if (bus.mem_en === 1'b1) en_cnt++;
            if (lat == poke) begin
                start = 1'b1; test_x = 16'sd100; n_points = '0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        @(posedge clk); #1;
        busy_after = busy;
        done_after = done;
    endtask

    task automatic test_reset();
        int en_seen;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %b expected 0", bus.mem_en); end
        checks++; if (bus.mem_addr !== 10'd0) begin errors++; $display("FAIL rst_mem_addr: got %0d expected 0", bus.mem_addr); end
        checks++; if (result_label !== 2'd0) begin errors++; $display("FAIL rst_label: got %0d expected 0", result_label); end
        checks++; if (min_dist !== ALL_ONES) begin errors++; $display("FAIL rst_min_dist: got %0h expected %0h", min_dist, ALL_ONES); end
        checks++; if (nbr_count !== 4'd0) begin errors++; $display("FAIL rst_nbr: got %0d expected 0", nbr_count); end
        @(negedge clk); rst = 1'b0;
        en_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.mem_en !== 1'b0 || busy !== 1'b0) en_seen++;
        end
        checks++; if (en_seen != 0) begin errors++; $display("FAIL rst_idle_quiet: got %0d active cycles expected 0", en_seen); end
        $display("reset: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_basic();
        int lat, en; logic b0, ba, da;
        load_basic();
        run(5, 0, 0, -1, lat, en, b0, ba, da);
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", b0); end
        checks++; if (lat != 16) begin errors++; $display("FAIL basic_latency: got %0d expected 16", lat); end
        checks++; if (en != 5) begin errors++; $display("FAIL basic_mem_en: got %0d expected 5", en); end
        checks++; if (result_label !== 2'd1) begin errors++; $display("FAIL basic_label: got %0d expected 1", result_label); end
        checks++; if (min_dist !== 33'd1) begin errors++; $display("FAIL basic_min_dist: got %0d expected 1", min_dist); end
        checks++; if (nbr_count !== 4'd4) begin errors++; $display("FAIL basic_nbr: got %0d expected 4", nbr_count); end
        checks++; if (ba !== 1'b0 || da !== 1'b0) begin errors++; $display("FAIL basic_end: got busy=%b done=%b expected 0 0", ba, da); end
        checks++; if (result_label !== 2'd1 || nbr_count !== 4'd4) begin errors++; $display("FAIL basic_hold: got %0d/%0d expected 1/4", result_label, nbr_count); end
        $display("basic: lat=%0d label=%0d min=%0d nbr=%0d", lat, result_label, min_dist, nbr_count);
    endtask

    task automatic test_zero();
        int lat, en; logic b0, ba, da;
        run(0, 7, 7, -1, lat, en, b0, ba, da);
        checks++; if (lat != 1) begin errors++; $display("FAIL zero_latency: got %0d expected 1", lat); end
        checks++; if (en != 0) begin errors++; $display("FAIL zero_mem_en: got %0d expected 0", en); end
        checks++; if (result_label !== 2'd0) begin errors++; $display("FAIL zero_label: got %0d expected 0", result_label); end
        checks++; if (min_dist !== ALL_ONES) begin errors++; $display("FAIL zero_min_dist: got %0h expected %0h", min_dist, ALL_ONES); end
        checks++; if (nbr_count !== 4'd0) begin errors++; $display("FAIL zero_nbr: got %0d expected 0", nbr_count); end
        checks++; if (ba !== 1'b0) begin errors++; $display("FAIL zero_busy_end: got %b expected 0", ba); end
        $display("zero: lat=%0d label=%0d nbr=%0d", lat, result_label, nbr_count);
    endtask

    task automatic test_ties();
        int lat, en; logic b0, ba, da;
        load_ties();
        run(2, 0, 0, -1, lat, en, b0, ba, da);
        checks++; if (lat != 7) begin errors++; $display("FAIL ties_latency: got %0d expected 7", lat); end
        checks++; if (nbr_count !== 4'd2) begin errors++; $display("FAIL ties_nbr: got %0d expected 2", nbr_count); end
        checks++; if (result_label !== 2'd1) begin errors++; $display("FAIL ties_label: got %0d expected 1", result_label); end
        checks++; if (min_dist !== 33'd4) begin errors++; $display("FAIL ties_min_dist: got %0d expected 4", min_dist); end
        $display("ties: lat=%0d label=%0d min=%0d nbr=%0d", lat, result_label, min_dist, nbr_count);
    endtask

    task automatic test_extremes();
        int lat, en; logic b0, ba, da;
        set_pt(0, 32767, 32767, 3);
        run(1, -32768, -32768, -1, lat, en, b0, ba, da);
        checks++; if (lat != 4) begin errors++; $display("FAIL ext_latency: got %0d expected 4", lat); end
        checks++; if (min_dist !== 33'd8589672450) begin errors++; $display("FAIL ext_min_dist: got %0d expected 8589672450", min_dist); end
        checks++; if (result_label !== 2'd3) begin errors++; $display("FAIL ext_label: got %0d expected 3", result_label); end
        checks++; if (nbr_count !== 4'd1) begin errors++; $display("FAIL ext_nbr: got %0d expected 1", nbr_count); end
        $display("extremes: lat=%0d label=%0d min=%0d", lat, result_label, min_dist);
    endtask

    task automatic test_start_while_busy();
        int lat, en; logic b0, ba, da;
        load_basic();
        run(5, 0, 0, 5, lat, en, b0, ba, da);
        checks++; if (lat != 16) begin errors++; $display("FAIL busy_start_latency: got %0d expected 16", lat); end
        checks++; if (en != 5) begin errors++; $display("FAIL busy_start_mem_en: got %0d expected 5", en); end
        checks++; if (result_label !== 2'd1 || min_dist !== 33'd1 || nbr_count !== 4'd4) begin
            errors++; $display("FAIL busy_start_result: got %0d/%0d/%0d expected 1/1/4", result_label, min_dist, nbr_count);
        end
        $display("start_while_busy: lat=%0d label=%0d", lat, result_label);
    endtask

    task automatic test_reset_mid_scan();
        int lat, en, active; logic b0, ba, da;
        load_basic();
        @(negedge clk);
        test_x = '0; test_y = '0; n_points = 11'd5; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (bus.mem_en !== 1'b1) begin errors++; $display("FAIL mid_read_active: got %b expected 1", bus.mem_en); end
        #2; rst = 1'b1; #1;
        checks++; if (busy !== 1'b0 || bus.mem_en !== 1'b0 || bus.mem_addr !== 10'd0) begin
            errors++; $display("FAIL mid_rst_idle: got busy=%b en=%b addr=%0d expected 0 0 0", busy, bus.mem_en, bus.mem_addr);
        end
        checks++; if (min_dist !== ALL_ONES || nbr_count !== 4'd0 || result_label !== 2'd0) begin
            errors++; $display("FAIL mid_rst_results: got %0h/%0d/%0d expected all-ones/0/0", min_dist, nbr_count, result_label);
        end
        active = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.mem_en !== 1'b0 || done !== 1'b0) active++;
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.mem_en !== 1'b0 || busy !== 1'b0) active++;
        end
        checks++; if (active != 0) begin errors++; $display("FAIL mid_rst_quiet: got %0d active cycles expected 0", active); end
        load_ties();
        run(2, 0, 0, -1, lat, en, b0, ba, da);
        checks++; if (lat != 7 || result_label !== 2'd1 || min_dist !== 33'd4 || nbr_count !== 4'd2) begin
            errors++; $display("FAIL mid_rst_rerun: got lat=%0d %0d/%0d/%0d expected 7 1/4/2", lat, result_label, min_dist, nbr_count);
        end
        $display("reset_mid_scan: rerun lat=%0d label=%0d", lat, result_label);
    endtask

    task automatic test_back_to_back();
        int lat, en; logic b0, ba, da;
        load_basic();
        run(5, 0, 0, -1, lat, en, b0, ba, da);
        checks++; if (result_label !== 2'd1 || nbr_count !== 4'd4) begin errors++; $display("FAIL b2b_first: got %0d/%0d expected 1/4", result_label, nbr_count); end
        // Points 0/1 now at dist 4 each (labels 2,1); list must start empty.
        load_ties();
        run(2, 0, 0, -1, lat, en, b0, ba, da);
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b expected 1", b0); end
        checks++; if (lat != 7 || nbr_count !== 4'd2 || result_label !== 2'd1 || min_dist !== 33'd4) begin
            errors++; $display("FAIL b2b_second: got lat=%0d %0d/%0d/%0d expected 7 1/4/2", lat, result_label, min_dist, nbr_count);
        end
        $display("back_to_back: lat=%0d label=%0d nbr=%0d", lat, result_label, nbr_count);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            px[i] = '0; py[i] = '0; pl[i] = '0;
        end
        bus.mem_x = '0; bus.mem_y = '0; bus.mem_label = '0;
        test_reset();
        test_basic();
        test_zero();
        test_ties();
        test_extremes();
        test_start_while_busy();
        test_reset_mid_scan();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
